// File: rtl/cordic_pkg.sv
// Shared constants and elaboration-time helpers for the CORDIC sin/cos pipeline.
package cordic_pkg;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b01;
    localparam logic [1:0] Q2 = 2'b10;
    localparam logic [1:0] Q3 = 2'b11;

    // CORDIC gain 0.6072529 as a ratio of integers.
    localparam longint GAIN_NUM = 6072529;
    localparam longint GAIN_DEN = 10000000;

    localparam int ATAN_FRAC = 60;
    // 2*pi with ATAN_FRAC fractional bits.
    localparam logic [127:0] TWO_PI_FX = 128'h6487_ED51_10B4_611A;

    // round(atan(2^-i) / (2*pi) * 2^z_w), via a fixed-point Taylor series.
    function automatic logic [63:0] atan_val(input int i, input int z_w);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] p;
        logic [127:0] sum;
        logic [127:0] r;
        if (i == 0) begin
            return 64'(1) << (z_w - 3);
        end
        x   = 128'(1) << (ATAN_FRAC - i);
        x2  = (x * x) >> ATAN_FRAC;
        p   = x;
        sum = x;
        for (int k = 1; k < 32; k++) begin
            p = (p * x2) >> ATAN_FRAC;
            if ((k % 2) != 0) begin
                sum = sum - p / 128'(2 * k + 1);
            end else begin
                sum = sum + p / 128'(2 * k + 1);
            end
        end
        r = ((sum << z_w) + (TWO_PI_FX >> 1)) / TWO_PI_FX;
        return r[63:0];
    endfunction

    // Pre-scaled start vector magnitude: round(gain * full_scale) << guard.
    function automatic longint k0_val(input int xy_w, input int guard);
        longint amp;
        amp = (longint'(1) << (xy_w - 1)) - 1;
        return ((amp * GAIN_NUM + GAIN_DEN / 2) / GAIN_DEN) << guard;
    endfunction

    function automatic bit stages_legal(input int stages, input int z_w);
        return (stages >= 4) && (stages <= 30) && (stages <= z_w - 2);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC rotation iteration with a fixed shift; valid and tag ride along.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int SHIFT = 0,
    parameter int XY_IW = 19,
    parameter int Z_W   = 32,
    parameter int TAG_W = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic signed [XY_IW-1:0] i_x,
    input  logic signed [XY_IW-1:0] i_y,
    input  logic signed [Z_W-1:0]   i_z,
    input  logic [TAG_W-1:0]        i_tag,
    output logic                    o_valid,
    output logic signed [XY_IW-1:0] o_x,
    output logic signed [XY_IW-1:0] o_y,
    output logic signed [Z_W-1:0]   o_z,
    output logic [TAG_W-1:0]        o_tag
);

    localparam logic [63:0]        ATAN_FULL = atan_val(SHIFT, Z_W);
    localparam logic signed [Z_W-1:0] ATAN   = ATAN_FULL[Z_W-1:0];

    logic signed [XY_IW-1:0] w_x_sh;
    logic signed [XY_IW-1:0] w_y_sh;
    logic signed [XY_IW-1:0] w_x_nxt;
    logic signed [XY_IW-1:0] w_y_nxt;
    logic signed [Z_W-1:0]   w_z_nxt;

    logic                    r_valid;
    logic signed [XY_IW-1:0] r_x;
    logic signed [XY_IW-1:0] r_y;
    logic signed [Z_W-1:0]   r_z;
    logic [TAG_W-1:0]        r_tag;

    assign w_x_sh = i_x >>> SHIFT;
    assign w_y_sh = i_y >>> SHIFT;

    // Negative residual angle rotates clockwise, otherwise counter-clockwise.
    always_comb begin
        w_x_nxt = i_x - w_y_sh;
        w_y_nxt = i_y + w_x_sh;
        w_z_nxt = i_z - ATAN;
        if (i_z[Z_W-1]) begin
            w_x_nxt = i_x + w_y_sh;
            w_y_nxt = i_y - w_x_sh;
            w_z_nxt = i_z + ATAN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_tag   <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_z     <= w_z_nxt;
            r_tag   <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;
    assign o_tag   = r_tag;

endmodule

// File: rtl/cordic_sincos_pipe.sv
// Fully pipelined rotation-mode CORDIC: cos and sin of a binary angle, one sample per cycle.
// Define CORDIC_ROUND_EN for round-half-up output scaling instead of truncation.
module cordic_sincos_pipe
    import cordic_pkg::*;
#(
    parameter int XY_W   = 16,
    parameter int Z_W    = 32,
    parameter int STAGES = 16,
    parameter int GUARD  = 2,
    parameter int TAG_W  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Z_W-1:0]         in_angle,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [XY_W-1:0] out_cos,
    output logic signed [XY_W-1:0] out_sin,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int XY_IW = XY_W + GUARD + 1;
    localparam logic signed [XY_IW-1:0] K0 = XY_IW'(k0_val(XY_W, GUARD));
    localparam longint AMP = (longint'(1) << (XY_W - 1)) - 1;
    localparam logic signed [XY_IW:0] SAT_HI = (XY_IW + 1)'(AMP);
    localparam logic signed [XY_IW:0] SAT_LO = -SAT_HI;

    if (!stages_legal(STAGES, Z_W)) begin : g_bad_stages
        $error("cordic_sincos_pipe: STAGES must be in 4..min(30, Z_W-2)");
    end

`ifdef CORDIC_ROUND_EN
    if (GUARD < 1) begin : g_bad_guard
        $error("cordic_sincos_pipe: rounding needs GUARD >= 1");
    end
    localparam logic signed [XY_IW:0] RND = (XY_IW + 1)'(longint'(1) << (GUARD - 1));
`endif

    logic                    w_en;
    logic signed [XY_IW-1:0] w_px;
    logic signed [XY_IW-1:0] w_py;
    logic signed [Z_W-1:0]   w_pz;

    logic                    r_v0;
    logic signed [XY_IW-1:0] r_x0;
    logic signed [XY_IW-1:0] r_y0;
    logic signed [Z_W-1:0]   r_z0;
    logic [TAG_W-1:0]        r_tag0;

    logic                    w_v   [STAGES+1];
    logic signed [XY_IW-1:0] w_x   [STAGES+1];
    logic signed [XY_IW-1:0] w_y   [STAGES+1];
    logic signed [Z_W-1:0]   w_z   [STAGES+1];
    logic [TAG_W-1:0]        w_tag [STAGES+1];

    logic w_unused_z;

    assign w_en     = ~w_v[STAGES] | out_ready;
    assign in_ready = w_en;

    // Fold quadrants 1 and 2 onto +/-90 deg so the iterations only see [-90, 90).
    always_comb begin
        w_px = K0;
        w_py = '0;
        w_pz = in_angle;
        unique case (in_angle[Z_W-1 -: 2])
            Q1: begin
                w_px = '0;
                w_py = K0;
                w_pz = {2'b00, in_angle[Z_W-3:0]};
            end
            Q2: begin
                w_px = '0;
                w_py = -K0;
                w_pz = {2'b11, in_angle[Z_W-3:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v0   <= 1'b0;
            r_x0   <= '0;
            r_y0   <= '0;
            r_z0   <= '0;
            r_tag0 <= '0;
        end else if (w_en) begin
            r_v0   <= in_valid;
            r_x0   <= w_px;
            r_y0   <= w_py;
            r_z0   <= w_pz;
            r_tag0 <= in_tag;
        end
    end

    assign w_v[0]   = r_v0;
    assign w_x[0]   = r_x0;
    assign w_y[0]   = r_y0;
    assign w_z[0]   = r_z0;
    assign w_tag[0] = r_tag0;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        cordic_stage #(
            .SHIFT (i),
            .XY_IW (XY_IW),
            .Z_W   (Z_W),
            .TAG_W (TAG_W)
        ) u_stage (
            .clock   (clock),
            .reset   (reset),
            .i_en    (w_en),
            .i_valid (w_v[i]),
            .i_x     (w_x[i]),
            .i_y     (w_y[i]),
            .i_z     (w_z[i]),
            .i_tag   (w_tag[i]),
            .o_valid (w_v[i+1]),
            .o_x     (w_x[i+1]),
            .o_y     (w_y[i+1]),
            .o_z     (w_z[i+1]),
            .o_tag   (w_tag[i+1])
        );
    end

    // Drop guard bits, then clamp symmetrically so the most-negative code never appears.
    function automatic logic signed [XY_W-1:0] scale_sat(input logic signed [XY_IW-1:0] v);
        logic signed [XY_IW:0] w_ext;
        logic signed [XY_IW:0] w_scaled;
        w_ext = {v[XY_IW-1], v};
`ifdef CORDIC_ROUND_EN
        w_scaled = (w_ext + RND) >>> GUARD;
`else
        w_scaled = w_ext >>> GUARD;
`endif
        if (w_scaled > SAT_HI) begin
            return SAT_HI[XY_W-1:0];
        end
        if (w_scaled < SAT_LO) begin
            return SAT_LO[XY_W-1:0];
        end
        return w_scaled[XY_W-1:0];
    endfunction

    assign out_valid  = w_v[STAGES];
    assign out_cos    = scale_sat(w_x[STAGES]);
    assign out_sin    = scale_sat(w_y[STAGES]);
    assign out_tag    = w_tag[STAGES];
    assign w_unused_z = ^w_z[STAGES];

endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// Randomised bench for cordic_sincos_pipe against a real-valued sin/cos reference.
module tb_cordic_sincos_pipe;

    localparam int     XY_W   = 16;
    localparam int     Z_W    = 32;
    localparam int     STAGES = 16;
    localparam int     GUARD  = 2;
    localparam int     TAG_W  = 4;
    localparam longint TOL    = 4;
    localparam real    PI     = 3.14159265358979323846;
    localparam real    AMP_R  = 32767.0;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [Z_W-1:0]         in_angle;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [XY_W-1:0] out_cos;
    logic signed [XY_W-1:0] out_sin;
    logic [TAG_W-1:0]       out_tag;

    int n_cmp = 0;
    int n_err = 0;

    // Angles waiting to be offered, and accepted samples with their acceptance edge index.
    logic [Z_W-1:0]   feed   [$];
    logic [Z_W-1:0]   sb_ang [$];
    logic [TAG_W-1:0] sb_tag [$];
    int               sb_edge[$];
    int               en_edges = 0;
    logic [TAG_W-1:0] tag_ctr  = '0;

    always #5 clock = ~clock;

    cordic_sincos_pipe #(
        .XY_W   (XY_W),
        .Z_W    (Z_W),
        .STAGES (STAGES),
        .GUARD  (GUARD),
        .TAG_W  (TAG_W)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cos   (out_cos),
        .out_sin   (out_sin),
        .out_tag   (out_tag)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp,
                             input longint tol = 0);
        n_cmp++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (tol %0d) at %0t",
                     tag, obs, exp, tol, $time);
        end
    endtask

    function automatic longint ref_val(input logic [Z_W-1:0] a, input bit want_sin);
        real th;
        real v;
        th = 2.0 * PI * real'(longint'(a)) / (2.0 ** Z_W);
        v  = AMP_R * (want_sin ? $sin(th) : $cos(th));
        return longint'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
    endfunction

    task automatic consume();
        logic [Z_W-1:0]   a;
        logic [TAG_W-1:0] t;
        if (sb_ang.size() == 0) begin
            check_val("unexpected_out", longint'(sb_ang.size()), 1);
            return;
        end
        a = sb_ang.pop_front();
        t = sb_tag.pop_front();
        void'(sb_edge.pop_front());
        check_val("cos", longint'(out_cos), ref_val(a, 1'b0), TOL);
        check_val("sin", longint'(out_sin), ref_val(a, 1'b1), TOL);
        check_val("tag", longint'(out_tag), longint'(t));
        check_val("no_min_code",
                  longint'(out_cos != 16'sh8000 && out_sin != 16'sh8000), 1);
    endtask

    // One clock: check output validity, drive new inputs, then account for the coming edge.
    task automatic cycle(input bit rnd);
        bit exp_v;
        bit en;
        @(negedge clock);
        exp_v = (sb_ang.size() != 0) && (en_edges - sb_edge[0] >= STAGES);
        check_val("out_valid", longint'(out_valid), longint'(exp_v));
        out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
        if (feed.size() != 0 && (!rnd || $urandom_range(3) != 0)) begin
            in_valid = 1'b1;
            in_angle = feed[0];
            in_tag   = tag_ctr;
        end else begin
            in_valid = 1'b0;
            in_angle = $urandom;
            in_tag   = TAG_W'($urandom);
        end
        #1;
        en = !out_valid || out_ready;
        check_val("in_ready", longint'(in_ready), longint'(en));
        if (out_valid && out_ready) begin
            consume();
        end
        if (en) begin
            en_edges++;
        end
        if (in_valid && en) begin
            sb_ang.push_back(in_angle);
            sb_tag.push_back(in_tag);
            sb_edge.push_back(en_edges);
            void'(feed.pop_front());
            tag_ctr++;
        end
    endtask

    task automatic run(input bit rnd, input int budget);
        int n;
        n = 0;
        while ((feed.size() != 0 || sb_ang.size() != 0) && n < budget) begin
            cycle(rnd);
            n++;
        end
        check_val("drain", longint'(feed.size() + sb_ang.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check_val("rst_valid", longint'(out_valid), 0);
        check_val("rst_cos", longint'(out_cos), 0);
        check_val("rst_sin", longint'(out_sin), 0);
        check_val("rst_tag", longint'(out_tag), 0);
        sb_ang.delete();
        sb_tag.delete();
        sb_edge.delete();
        reset = 1'b0;
        #1;
        check_val("rst_ready", longint'(in_ready), 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_angle  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        do_reset();

        // Axes, diagonals and quadrant boundaries.
        feed = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000,
                 32'h2000_0000, 32'hE000_0000, 32'h3FFF_FFFF, 32'h8000_0001,
                 32'hBFFF_FFFF, 32'hFFFF_FFFF};
        run(1'b0, 200);

        // Mid-stream reset with ten samples in flight.
        for (int k = 0; k < 30; k++) begin
            feed.push_back($urandom);
        end
        repeat (10) cycle(1'b0);
        do_reset();
        run(1'b0, 300);

        // Ramp around the circle with random bubbles and back-pressure.
        for (int k = 0; k < 1000; k++) begin
            feed.push_back(32'(k * 32'h0041_8937));
        end
        run(1'b1, 8000);

        for (int k = 0; k < 200; k++) begin
            feed.push_back($urandom);
        end
        run(1'b1, 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
